// File: rtl/zilla_div_rem_unit_if.sv
// ----------------------------------------------------------------------------
// zilla_div_rem_unit_if
//
// Request/response bundle for the iterative divide/remainder unit.
//
// Parameter:
//   DATA_WIDTH  operand and result width
//
// Signals:
//   valid_i     request strobe (requester -> unit)
//   op_i        2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   dividend_i  dividend
//   divisor_i   divisor
//   kill_i      flush; aborts an operation that is still calculating
//   busy_o      unit not idle; requests are ignored while high
//   valid_o     result_o carries a fresh result this cycle
//   result_o    quotient or remainder, held between results
//
// Modports:
//   master      requester side
//   slave       unit side
// ----------------------------------------------------------------------------
interface zilla_div_rem_unit_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  valid_i;
  logic [1:0]            op_i;
  logic [DATA_WIDTH-1:0] dividend_i;
  logic [DATA_WIDTH-1:0] divisor_i;
  logic                  kill_i;
  logic                  busy_o;
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output valid_i,
    output op_i,
    output dividend_i,
    output divisor_i,
    output kill_i,
    input  busy_o,
    input  valid_o,
    input  result_o
  );

  modport slave (
    input  valid_i,
    input  op_i,
    input  dividend_i,
    input  divisor_i,
    input  kill_i,
    output busy_o,
    output valid_o,
    output result_o
  );

endinterface

// File: rtl/zilla_div_rem_unit.sv
// ----------------------------------------------------------------------------
// zilla_div_rem_unit
//
// Iterative divider producing one quotient bit per cycle by restoring
// division on unsigned magnitudes. Signed operations divide magnitudes and
// fix the signs at the end: the quotient is negated when operand signs
// differ, the remainder takes the dividend's sign.
//
// Divide by zero yields an all-ones quotient and the dividend as remainder.
// Signed overflow (most negative / -1) yields the dividend as quotient and
// a zero remainder. Both fall out of the normal datapath, except that the
// quotient sign fix-up is suppressed for a zero divisor.
//
// Sequence: IDLE -> CALC (DATA_WIDTH cycles) -> DONE (valid_o) -> IDLE.
// kill_i aborts CALC silently; it is ignored in DONE and blocks an accept
// in IDLE.
//
// Configuration macro:
//   ZILLA_DIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow
//                           requests jump straight from IDLE to DONE
//                           (result one cycle after accept).
//
// Parameter:
//   DATA_WIDTH  operand/result width, even, 8..64
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   bus         zilla_div_rem_unit_if.slave (request, kill, busy, result)
// ----------------------------------------------------------------------------
module zilla_div_rem_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  zilla_div_rem_unit_if.slave  bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]    state_reg,  state_next;
  logic [1:0]    op_reg,     op_next;
  logic [W-1:0]  quo_reg,    quo_next;    // dividend bits shift out, quotient bits shift in
  logic [W-1:0]  rem_reg,    rem_next;    // partial remainder
  logic [W-1:0]  dvs_reg,    dvs_next;    // divisor magnitude
  logic [W-1:0]  result_reg, result_next;
  logic [CW-1:0] cnt_reg,    cnt_next;
  logic          neg_q_reg,  neg_q_next;
  logic          neg_r_reg,  neg_r_next;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic         accept;
  logic         is_signed;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic         div_zero;

  assign accept    = (state_reg == ST_IDLE) && bus.valid_i && !bus.kill_i;
  assign is_signed = !bus.op_i[0];
  assign a_neg     = is_signed && bus.dividend_i[W-1];
  assign b_neg     = is_signed && bus.divisor_i[W-1];
  assign a_mag     = a_neg ? (W'(0) - bus.dividend_i) : bus.dividend_i;
  assign b_mag     = b_neg ? (W'(0) - bus.divisor_i)  : bus.divisor_i;
  assign div_zero  = (bus.divisor_i == '0);

`ifdef ZILLA_DIV_EARLY_OUT_EN
  logic         signed_ovf;
  logic         early_out;
  logic [W-1:0] early_result;

  assign signed_ovf = is_signed
                   && (bus.dividend_i == {1'b1, {(W-1){1'b0}}})
                   && (bus.divisor_i == '1);
  assign early_out  = div_zero || signed_ovf;
  assign early_result = div_zero ? (bus.op_i[1] ? bus.dividend_i : '1)
                                 : (bus.op_i[1] ? '0 : bus.dividend_i);
`endif

  // --------------------------------------------------------------------------
  // One restoring step. The shifted remainder needs one extra bit; once the
  // subtraction is taken the result is below the divisor, so W bits suffice
  // and the modulo-2^W subtraction is exact.
  // --------------------------------------------------------------------------
  logic [W:0]   shifted;
  logic         step_ge;
  logic [W-1:0] step_sub;
  logic [W-1:0] step_rem;
  logic [W-1:0] step_quo;
  logic [W-1:0] final_q;
  logic [W-1:0] final_r;
  logic [W-1:0] final_result;

  assign shifted  = {rem_reg, quo_reg[W-1]};
  assign step_ge  = (shifted >= {1'b0, dvs_reg});
  assign step_sub = shifted[W-1:0] - dvs_reg;
  assign step_rem = step_ge ? step_sub : shifted[W-1:0];
  assign step_quo = {quo_reg[W-2:0], step_ge};

  assign final_q      = neg_q_reg ? (W'(0) - step_quo) : step_quo;
  assign final_r      = neg_r_reg ? (W'(0) - step_rem) : step_rem;
  assign final_result = op_reg[1] ? final_r : final_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    quo_next    = quo_reg;
    rem_next    = rem_reg;
    dvs_next    = dvs_reg;
    result_next = result_reg;
    cnt_next    = cnt_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          op_next    = bus.op_i;
          quo_next   = a_mag;
          rem_next   = '0;
          dvs_next   = b_mag;
          cnt_next   = '0;
          // A zero divisor must leave the all-ones quotient untouched.
          neg_q_next = (a_neg ^ b_neg) && !div_zero;
          neg_r_next = a_neg;
          state_next = ST_CALC;
`ifdef ZILLA_DIV_EARLY_OUT_EN
          if (early_out) begin
            result_next = early_result;
            state_next  = ST_DONE;
          end
`endif
        end
      end

      ST_CALC: begin
        if (bus.kill_i) begin
          state_next = ST_IDLE;
        end else begin
          quo_next = step_quo;
          rem_next = step_rem;
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == LAST_STEP) begin
            result_next = final_result;
            state_next  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      quo_reg    <= quo_next;
      rem_reg    <= rem_next;
      dvs_reg    <= dvs_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy_o   = (state_reg != ST_IDLE);
  assign bus.valid_o  = (state_reg == ST_DONE);
  assign bus.result_o = result_reg;

endmodule

// File: tb/tb_zilla_div_rem_unit.sv
// ----------------------------------------------------------------------------
// tb_zilla_div_rem_unit
//
// Scoreboard bench: the driver pushes each expected result (with its expected
// latency) when it issues a request; a monitor on the falling edge pops and
// compares whenever valid_o is high, and checks that result_o holds between
// results and that outputs are zero during reset.
// ----------------------------------------------------------------------------
module tb_zilla_div_rem_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zilla_div_rem_unit_if #(.DATA_WIDTH(W)) bus ();

  zilla_div_rem_unit #(.DATA_WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           t0;
    string        name;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] last_exp = '0;
  int           tests = 0;
  int           fails = 0;
  int           cycle_cnt = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Reference: plain arithmetic plus the two architectural special cases.
  function automatic logic [W-1:0] model(input logic [1:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    logic [W-1:0]        r;
    sa = a;
    sb = b;
    if (b == '0) begin
      r = op[1] ? a : '1;
    end else if (!op[0]) begin
      if (a == MIN_NEG && b == '1) r = op[1] ? '0 : a;
      else if (op[1])              r = sa % sb;
      else                         r = sa / sb;
    end else begin
      r = op[1] ? (a % b) : (a / b);
    end
    return r;
  endfunction

  function automatic int exp_latency(input logic [1:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    bit special;
    special = (b == '0) || (!op[0] && a == MIN_NEG && b == '1);
`ifdef ZILLA_DIV_EARLY_OUT_EN
    return special ? 1 : W + 1;
`else
    return special ? W + 1 : W + 1;
`endif
  endfunction

  task automatic check_val(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      check_int("rst_busy", int'(bus.busy_o), 0);
      check_int("rst_valid", int'(bus.valid_o), 0);
      check_val("rst_result", bus.result_o, '0);
      exp_q.delete();
      last_exp = '0;
    end else if (bus.valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got valid_o=1 result 0x%h, required valid_o=0",
                 bus.result_o);
      end else begin
        mon_e = exp_q.pop_front();
        check_val({"result ", mon_e.name}, bus.result_o, mon_e.res);
        check_int({"latency ", mon_e.name}, cycle_cnt - mon_e.t0, mon_e.lat);
        $display("[TB] %s -> 0x%h (latency %0d)", mon_e.name, bus.result_o,
                 cycle_cnt - mon_e.t0);
        last_exp = mon_e.res;
      end
    end else begin
      check_val("hold", bus.result_o, last_exp);
    end
  end

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic wait_idle();
    int n = 0;
    while ((bus.busy_o || exp_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_int("idle_timeout", (n >= 200) ? 1 : 0, 0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit push);
    exp_t e;
    wait_idle();
    bus.valid_i    = 1'b1;
    bus.op_i       = op;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    if (push) begin
      e.res  = model(op, a, b);
      e.lat  = exp_latency(op, a, b);
      e.t0   = cycle_cnt;
      e.name = $sformatf("op%0d 0x%h/0x%h", op, a, b);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.valid_i    = 1'b0;
    bus.dividend_i = $urandom;
    bus.divisor_i  = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    bus.valid_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.kill_i     = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases
    issue(OP_DIVU, 32'd100, 32'd7, 1);
    issue(OP_REMU, 32'd100, 32'd7, 1);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 1);
    issue(OP_DIV,  MIN_NEG, 32'hFFFF_FFFF, 1);
    issue(OP_REM,  MIN_NEG, 32'hFFFF_FFFF, 1);
    issue(OP_DIVU, 32'd5, 32'd0, 1);
    issue(OP_REMU, 32'd5, 32'd0, 1);
    issue(OP_DIV,  32'hFFFF_FF00, 32'd0, 1);
    issue(OP_REM,  32'hFFFF_FF00, 32'd0, 1);
    issue(OP_DIVU, MIN_NEG, 32'hFFFF_FFFF, 1);

    // Requests while busy must be ignored
    issue(OP_DIV, 32'hFFFF_FC18, 32'd7, 1);
    repeat (4) begin
      bus.valid_i    = 1'b1;
      bus.op_i       = 2'($urandom);
      bus.dividend_i = $urandom;
      bus.divisor_i  = $urandom;
      @(posedge clk);
      #1;
    end
    bus.valid_i = 1'b0;
    wait_idle();

    // Kill during the 10th CALC cycle
    issue(OP_DIVU, 32'd123456, 32'd77, 0);
    repeat (9) @(posedge clk);
    #1;
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    check_int("kill_busy", int'(bus.busy_o), 0);
    issue(OP_DIVU, 32'd9, 32'd3, 1);
    wait_idle();

    // Kill beats a simultaneous request in IDLE
    bus.valid_i    = 1'b1;
    bus.kill_i     = 1'b1;
    bus.op_i       = OP_DIVU;
    bus.dividend_i = 32'd50;
    bus.divisor_i  = 32'd5;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    check_int("kill_priority_busy", int'(bus.busy_o), 0);

    // Kill in DONE is ignored
    issue(OP_REMU, 32'd1000, 32'd33, 1);
    repeat (W) @(posedge clk);
    #1;
    bus.kill_i = 1'b1;
    @(posedge clk);
    #1;
    bus.kill_i = 1'b0;
    wait_idle();

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       begin a = MIN_NEG; b = '1; op[0] = 1'b0; end
        2:       b = W'($urandom_range(1, 15));
        3:       b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      issue(op, a, b, 1);
    end
    wait_idle();

    // Reset in the middle of a calculation
    issue(OP_DIV, $urandom, 32'd13, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_int("async_rst_busy", int'(bus.busy_o), 0);
    check_int("async_rst_valid", int'(bus.valid_o), 0);
    check_val("async_rst_result", bus.result_o, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (W + 8) @(posedge clk);
    #1;
    issue(OP_REM, 32'hFFFF_FF9C, 32'd7, 1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check_int("pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
